// File: rtl/multi_producer.sv
// Four-to-one round-robin merge: producers arbitrated each cycle, winner pushed into a FIFO feeding one consumer port.
// Latency: accept edge to d_out_valid is one cycle on an empty FIFO; d_out comes straight from the FIFO head.
// Backpressure: every producer ready is low while the FIFO is full (no push-through). MULTI_PRODUCER_TAG_EN adds d_out_src.
module multi_producer #(
    parameter int WIDTH      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_in_0,
    input  logic [WIDTH-1:0] d_in_1,
    input  logic [WIDTH-1:0] d_in_2,
    input  logic [WIDTH-1:0] d_in_3,
    input  logic             d_in_valid_0,
    input  logic             d_in_valid_1,
    input  logic             d_in_valid_2,
    input  logic             d_in_valid_3,
    output logic             d_in_ready_0,
    output logic             d_in_ready_1,
    output logic             d_in_ready_2,
    output logic             d_in_ready_3,
    output logic [WIDTH-1:0] d_out,
    output logic             d_out_valid,
    input  logic             d_out_ready
`ifdef MULTI_PRODUCER_TAG_EN
    ,
    output logic [1:0]       d_out_src
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
`ifdef MULTI_PRODUCER_TAG_EN
    localparam int EW = WIDTH + 2;
`else
    localparam int EW = WIDTH;
`endif
    localparam logic [CW-1:0] FULL_C  = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] din [4];
    logic [3:0]       vld;
    logic [1:0]       last_q, last_d;
    logic [1:0]       grant;
    logic [1:0]       idx;
    logic             any_valid;
    logic [CW-1:0]    count_q, count_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    entry;
    logic [EW-1:0]    head;
    logic             full;
    logic             push;
    logic             pop;

    always_comb begin
        din[0] = d_in_0;
        din[1] = d_in_1;
        din[2] = d_in_2;
        din[3] = d_in_3;
    end

    assign vld = {d_in_valid_3, d_in_valid_2, d_in_valid_1, d_in_valid_0};

    // Search starts one past the last winner, so the last winner has lowest priority.
    always_comb begin
        grant     = last_q;
        any_valid = 1'b0;
        idx       = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!any_valid && vld[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

    assign full = (count_q == FULL_C);
    // Gating with rst_n keeps every ready low while reset is held.
    assign push = any_valid & ~full & rst_n;
    assign pop  = (count_q != '0) & d_out_ready;

    assign d_in_ready_0 = push & (grant == 2'd0);
    assign d_in_ready_1 = push & (grant == 2'd1);
    assign d_in_ready_2 = push & (grant == 2'd2);
    assign d_in_ready_3 = push & (grant == 2'd3);

`ifdef MULTI_PRODUCER_TAG_EN
    assign entry = {grant, din[grant]};
`else
    assign entry = din[grant];
`endif

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        last_d   = push ? grant : last_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            last_q   <= 2'd3;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            last_q   <= last_d;
        end
    end

    // Storage needs no reset: nothing is visible unless count says so.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= entry;
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign d_out_valid = (count_q != '0);
    assign d_out       = d_out_valid ? head[WIDTH-1:0] : '0;
`ifdef MULTI_PRODUCER_TAG_EN
    assign d_out_src   = d_out_valid ? head[WIDTH +: 2] : 2'd0;
`endif

endmodule

// File: tb/tb_multi_producer.sv
// Bench for multi_producer: directed phases plus randomized traffic, checked against a queue-based reference model.
module tb_multi_producer;

    logic        clock = 1'b0;
    logic        rst_n;
    logic [15:0] din [4];
    logic        vin [4];
    logic        d_out_ready;
    logic [3:0]  rdy;
    logic [15:0] d_out;
    logic        d_out_valid;
`ifdef MULTI_PRODUCER_TAG_EN
    logic [1:0]  d_out_src;
`endif

    int tests  = 0;
    int failed = 0;
    int mq_dat [$];
    int mq_src [$];
    int m_last;
    int acc_port;

    multi_producer #(.WIDTH(16), .FIFO_DEPTH(4)) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .d_in_0       (din[0]),
        .d_in_1       (din[1]),
        .d_in_2       (din[2]),
        .d_in_3       (din[3]),
        .d_in_valid_0 (vin[0]),
        .d_in_valid_1 (vin[1]),
        .d_in_valid_2 (vin[2]),
        .d_in_valid_3 (vin[3]),
        .d_in_ready_0 (rdy[0]),
        .d_in_ready_1 (rdy[1]),
        .d_in_ready_2 (rdy[2]),
        .d_in_ready_3 (rdy[3]),
        .d_out        (d_out),
        .d_out_valid  (d_out_valid),
        .d_out_ready  (d_out_ready)
`ifdef MULTI_PRODUCER_TAG_EN
        ,
        .d_out_src    (d_out_src)
`endif
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_dat.delete();
        mq_src.delete();
        m_last   = 3;
        acc_port = -1;
    endtask

    // Called at a falling edge: check outputs, cross one rising edge, advance the model.
    task automatic cycle(input string tag);
        int  g;
        int  p;
        int  d;
        bit  full;
        bit  pop;
        #2;
        full = (mq_dat.size() == 4);
        g = -1;
        for (int j = 0; j < 4; j++) begin
            p = (m_last + 1 + j) % 4;
            if (g < 0 && vin[p]) g = p;
        end
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_rdy%0d", tag, k), 32'(rdy[k]), 32'(g == k && !full));
        end
        chk({tag, "_vld"}, 32'(d_out_valid), 32'(mq_dat.size() > 0));
        if (mq_dat.size() > 0) begin
            chk({tag, "_dat"}, 32'(d_out), 32'(mq_dat[0]));
`ifdef MULTI_PRODUCER_TAG_EN
            chk({tag, "_src"}, 32'(d_out_src), 32'(mq_src[0]));
`endif
        end
        acc_port = (!full) ? g : -1;
        d        = (acc_port >= 0) ? int'(din[acc_port]) : 0;
        pop      = (mq_dat.size() > 0) && d_out_ready;
        @(posedge clock);
        if (pop) begin
            void'(mq_dat.pop_front());
            void'(mq_src.pop_front());
        end
        if (acc_port >= 0) begin
            mq_dat.push_back(d);
            mq_src.push_back(acc_port);
            m_last = acc_port;
        end
        @(negedge clock);
    endtask

    task automatic set_valids(input logic [3:0] v);
        for (int k = 0; k < 4; k++) vin[k] = v[k];
    endtask

    initial begin
        rst_n       = 1'b0;
        d_out_ready = 1'b0;
        din[0] = 16'hAAAA; din[1] = 16'hBBBB; din[2] = 16'hCCCC; din[3] = 16'hDDDD;
        set_valids(4'b1111);
        model_reset();

        // Reset held with every producer valid.
        repeat (2) @(negedge clock);
        #2;
        for (int k = 0; k < 4; k++) chk($sformatf("rst_rdy%0d", k), 32'(rdy[k]), 32'd0);
        chk("rst_vld", 32'(d_out_valid), 32'd0);
        chk("rst_dat", 32'(d_out), 32'd0);
`ifdef MULTI_PRODUCER_TAG_EN
        chk("rst_src", 32'(d_out_src), 32'd0);
`endif
        @(negedge clock);
        rst_n = 1'b1;
        cycle("rel");
        chk("rel_first_port0", 32'(acc_port), 32'd0);

        set_valids(4'b0000);
        d_out_ready = 1'b1;
        cycle("drain0");

        // Single producer on port 1.
        din[1] = 16'h1234;
        set_valids(4'b0010);
        cycle("sp_acc");
        set_valids(4'b0000);
        cycle("sp_out");
        cycle("sp_idle");

        // Round-robin with all four producers valid and free-flowing output.
        din[0] = 16'hAAAA; din[1] = 16'hBBBB; din[2] = 16'hCCCC; din[3] = 16'hDDDD;
        set_valids(4'b1111);
        repeat (12) cycle("rr");

        // Fill to full, then one pop pulse.
        d_out_ready = 1'b0;
        repeat (6) cycle("full");
        d_out_ready = 1'b1;
        cycle("pulse_pop");
        d_out_ready = 1'b0;
        cycle("after_pop");
        cycle("refull");

        // Simultaneous push/pop holding the FIFO at two entries, wrapping pointers.
        set_valids(4'b0000);
        d_out_ready = 1'b1;
        repeat (2) cycle("to_two");
        set_valids(4'b1111);
        repeat (10) begin
            cycle("pp2");
            if (acc_port >= 0) din[acc_port] = 16'($urandom);
        end

        // Randomized traffic; a producer only changes data once accepted or idle.
        repeat (400) begin
            d_out_ready = ($urandom_range(0, 3) != 0);
            cycle("rnd");
            for (int k = 0; k < 4; k++) begin
                if (!vin[k] || acc_port == k) begin
                    vin[k] = ($urandom_range(0, 2) != 0);
                    din[k] = 16'($urandom);
                end
            end
        end

        // Async reset mid-burst with three entries queued.
        set_valids(4'b0000);
        d_out_ready = 1'b1;
        repeat (5) cycle("pre_drain");
        din[0] = 16'h0101; din[1] = 16'h0202; din[2] = 16'h0303; din[3] = 16'h0404;
        set_valids(4'b1111);
        d_out_ready = 1'b0;
        repeat (3) cycle("burst3");
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 32'(d_out_valid), 32'd0);
        chk("arst_dat", 32'(d_out), 32'd0);
        for (int k = 0; k < 4; k++) chk($sformatf("arst_rdy%0d", k), 32'(rdy[k]), 32'd0);
        model_reset();
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        din[0] = 16'h5000; din[1] = 16'h5001; din[2] = 16'h5002; din[3] = 16'h5003;
        set_valids(4'b0100);
        d_out_ready = 1'b1;
        cycle("post_acc");
        set_valids(4'b0000);
        cycle("post_out");
        cycle("post_idle");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
